// File: rtl/regfile_pkg.sv
// Package: regfile_pkg
// Purpose: shared defaults and elaboration helpers for the enable/clear
//   register file (regfile_ec) and its word register (reg_word_ec).
// Contents:
//   DEF_WIDTH, DEF_DEPTH, DEF_AW  default geometry
//   DEF_RESET_VAL                 default async-reset value of every word
//   clog2_ceil()                  minimum address bits for n words
package regfile_pkg;

  localparam int          DEF_WIDTH     = 32;
  localparam int          DEF_DEPTH     = 8;
  localparam int          DEF_AW        = 3;
  localparam logic [31:0] DEF_RESET_VAL = 32'h0000_0000;

  // Number of address bits needed to reach n distinct words.
  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_word_ec.sv
// Module: reg_word_ec
// Purpose: WIDTH-bit register with enable and synchronous clear.
//   Priority: async reset (Clrn=0) > sync clear (Sclrn=0) > load (En=1) > hold.
// Ports:
//   Clk    in   1      rising-edge clock
//   Clrn   in   1      asynchronous active-low reset, loads RESET_VAL
//   En     in   1      load enable
//   Sclrn  in   1      synchronous active-low clear, loads 0
//   D      in   WIDTH  load data
//   Q      out  WIDTH  stored value
module reg_word_ec
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             En,
  input  logic             Sclrn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Q <= RESET_VAL;
    end else if (!Sclrn) begin
      Q <= '0;
    end else if (En) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/regfile_ec.sv
// Module: regfile_ec
// Purpose: parametrised register file, 1 write port and 2 combinational read
//   ports, built from DEPTH reg_word_ec words. Sclrn=0 clears every word on
//   the clock edge and overrides any write. Out-of-range addresses
//   (>= DEPTH) ignore writes and read 0. With ZERO_REG=1 word 0 is a
//   constant 0 and writes to it are dropped.
// Optional feature: macro REGFILE_BYPASS_EN forwards Wdata to a read port in
//   the same cycle when the write would actually land (We=1, Sclrn=1,
//   in-range, not the zero register) and the addresses match.
// Ports:
//   Clk     in   1      rising-edge clock
//   Clrn    in   1      asynchronous active-low reset (words -> RESET_VAL)
//   Sclrn   in   1      synchronous active-low clear of all words
//   We      in   1      write enable
//   Waddr   in   AW     write address
//   Wdata   in   WIDTH  write data
//   Raddr1  in   AW     read address, port 1
//   Raddr2  in   AW     read address, port 2
//   Rdata1  out  WIDTH  read data, port 1
//   Rdata2  out  WIDTH  read data, port 2
module regfile_ec
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               AW        = DEF_AW,
  parameter bit               ZERO_REG  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Sclrn,
  input  logic             We,
  input  logic [AW-1:0]    Waddr,
  input  logic [WIDTH-1:0] Wdata,
  input  logic [AW-1:0]    Raddr1,
  input  logic [AW-1:0]    Raddr2,
  output logic [WIDTH-1:0] Rdata1,
  output logic [WIDTH-1:0] Rdata2
);

  if (DEPTH < 2 || DEPTH > 256 || AW < clog2_ceil(DEPTH)) begin : g_bad_cfg
    $error("regfile_ec: DEPTH must be 2..256 and 2**AW >= DEPTH");
  end

  logic [WIDTH-1:0] words [DEPTH];

  // An out-of-range Waddr matches no word, so such writes fall away here.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG && i == 0) begin : g_zero
      assign words[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = We && (Waddr == AW'(i));
      reg_word_ec #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_word (
        .Clk  (Clk),
        .Clrn (Clrn),
        .En   (en),
        .Sclrn(Sclrn),
        .D    (Wdata),
        .Q    (words[i])
      );
    end
  end

  // Read muxes default to 0, which covers out-of-range addresses.
  logic [WIDTH-1:0] stored1, stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Raddr1 == AW'(i)) stored1 = words[i];
      if (Raddr2 == AW'(i)) stored2 = words[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward only writes that will really commit; a pending clear keeps
  // showing the pre-clear contents.
  logic wr_ok;
  assign wr_ok = We && Sclrn && (32'(Waddr) < DEPTH) &&
                 (!ZERO_REG || (Waddr != '0));

  assign Rdata1 = (wr_ok && (Waddr == Raddr1)) ? Wdata : stored1;
  assign Rdata2 = (wr_ok && (Waddr == Raddr2)) ? Wdata : stored2;
`else
  assign Rdata1 = stored1;
  assign Rdata2 = stored2;
`endif

endmodule

// File: tb/tb_regfile_ec.sv
// Testbench: tb_regfile_ec
// Purpose: directed checks of regfile_ec in three configurations sharing one
//   stimulus bus: dut_z (DEPTH 8, ZERO_REG 1), dut_n (DEPTH 8, ZERO_REG 0),
//   dut_s (DEPTH 6, ZERO_REG 1). All use RESET_VAL 32'hAA.
module tb_regfile_ec;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn, sclrn, we;
  logic [2:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] z_rd1, z_rd2, n_rd1, n_rd2, s_rd1, s_rd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_ec #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG(1'b1), .RESET_VAL(32'h0000_00AA)) dut_z (
    .Clk(clk), .Clrn(clrn), .Sclrn(sclrn), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Raddr1(raddr1), .Raddr2(raddr2), .Rdata1(z_rd1), .Rdata2(z_rd2));

  regfile_ec #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG(1'b0), .RESET_VAL(32'h0000_00AA)) dut_n (
    .Clk(clk), .Clrn(clrn), .Sclrn(sclrn), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Raddr1(raddr1), .Raddr2(raddr2), .Rdata1(n_rd1), .Rdata2(n_rd2));

  regfile_ec #(.WIDTH(32), .DEPTH(6), .AW(3), .ZERO_REG(1'b1), .RESET_VAL(32'h0000_00AA)) dut_s (
    .Clk(clk), .Clrn(clrn), .Sclrn(sclrn), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Raddr1(raddr1), .Raddr2(raddr2), .Rdata1(s_rd1), .Rdata2(s_rd2));

  // Advance past the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b1; sclrn = 1'b1; we = 1'b0; waddr = 3'd0; wdata = '0;
    raddr1 = 3'd3; raddr2 = 3'd0;
    #3 clrn = 1'b0;
    #1;
    checks++;
    if (z_rd1 !== 32'hAA) begin errors++; $display("FAIL reset_async_w3 got=%h exp=%h", z_rd1, 32'hAA); end
    tick(); tick();
    clrn = 1'b1;
    #1;
    checks++;
    if (z_rd1 !== 32'hAA) begin errors++; $display("FAIL reset_w3 got=%h exp=%h", z_rd1, 32'hAA); end
    checks++;
    if (z_rd2 !== 32'h0) begin errors++; $display("FAIL reset_zero_w0 got=%h exp=%h", z_rd2, 32'h0); end
    checks++;
    if (n_rd2 !== 32'hAA) begin errors++; $display("FAIL reset_nozero_w0 got=%h exp=%h", n_rd2, 32'hAA); end
    raddr1 = 3'd7;
    #1;
    checks++;
    if (z_rd1 !== 32'hAA) begin errors++; $display("FAIL reset_w7 got=%h exp=%h", z_rd1, 32'hAA); end
  endtask

  task automatic test_write();
    write_word(3'd5, 32'hDEAD_BEEF);
    raddr1 = 3'd5; raddr2 = 3'd5;
    #1;
    checks++;
    if (z_rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_rd1_w5 got=%h exp=%h", z_rd1, 32'hDEAD_BEEF); end
    checks++;
    if (z_rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_rd2_w5 got=%h exp=%h", z_rd2, 32'hDEAD_BEEF); end
    raddr1 = 3'd4; raddr2 = 3'd6;
    #1;
    checks++;
    if (z_rd1 !== 32'hAA) begin errors++; $display("FAIL write_w4_untouched got=%h exp=%h", z_rd1, 32'hAA); end
    checks++;
    if (z_rd2 !== 32'hAA) begin errors++; $display("FAIL write_w6_untouched got=%h exp=%h", z_rd2, 32'hAA); end
  endtask

  task automatic test_zero_reg();
    write_word(3'd0, 32'h1234);
    raddr1 = 3'd0; raddr2 = 3'd0;
    #1;
    checks++;
    if (z_rd1 !== 32'h0) begin errors++; $display("FAIL zero_reg_on got=%h exp=%h", z_rd1, 32'h0); end
    checks++;
    if (n_rd1 !== 32'h1234) begin errors++; $display("FAIL zero_reg_off got=%h exp=%h", n_rd1, 32'h1234); end
    checks++;
    if (n_rd2 !== 32'h1234) begin errors++; $display("FAIL zero_reg_off_rd2 got=%h exp=%h", n_rd2, 32'h1234); end
  endtask

  task automatic test_sclr();
    for (int i = 1; i < 8; i++) write_word(3'(i), 32'h100 + i);
    raddr1 = 3'd7; raddr2 = 3'd1;
    #1;
    checks++;
    if (z_rd1 !== 32'h107) begin errors++; $display("FAIL sclr_preload_w7 got=%h exp=%h", z_rd1, 32'h107); end
    checks++;
    if (z_rd2 !== 32'h101) begin errors++; $display("FAIL sclr_preload_w1 got=%h exp=%h", z_rd2, 32'h101); end
    sclrn = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 32'h55; raddr1 = 3'd2;
    #1;
    // Pending clear: even with forwarding the stored value is still shown.
    checks++;
    if (z_rd1 !== 32'h102) begin errors++; $display("FAIL sclr_preedge_w2 got=%h exp=%h", z_rd1, 32'h102); end
    tick();
    sclrn = 1'b1; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i); raddr2 = 3'(7 - i);
      #1;
      checks++;
      if (z_rd1 !== 32'h0 || z_rd2 !== 32'h0)
        begin errors++; $display("FAIL sclr_zero_z addr=%0d got=%h/%h exp=0", i, z_rd1, z_rd2); end
      checks++;
      if (n_rd1 !== 32'h0) begin errors++; $display("FAIL sclr_zero_n addr=%0d got=%h exp=0", i, n_rd1); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp;
    for (int i = 1; i < 6; i++) write_word(3'(i), 32'h20 + i);
    write_word(3'd7, 32'hFF);
    write_word(3'd6, 32'hFF);
    for (int i = 0; i < 6; i++) begin
      raddr1 = 3'(i);
      exp = (i == 0) ? 32'h0 : 32'h20 + i;
      #1;
      checks++;
      if (s_rd1 !== exp) begin errors++; $display("FAIL oor_unchanged addr=%0d got=%h exp=%h", i, s_rd1, exp); end
    end
    raddr1 = 3'd7; raddr2 = 3'd6;
    #1;
    checks++;
    if (s_rd1 !== 32'h0) begin errors++; $display("FAIL oor_read7 got=%h exp=%h", s_rd1, 32'h0); end
    checks++;
    if (s_rd2 !== 32'h0) begin errors++; $display("FAIL oor_read6 got=%h exp=%h", s_rd2, 32'h0); end
    checks++;
    if (z_rd1 !== 32'hFF) begin errors++; $display("FAIL oor_depth8_w7 got=%h exp=%h", z_rd1, 32'hFF); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    write_word(3'd4, 32'h11);
    we = 1'b1; waddr = 3'd4; wdata = 32'h77; raddr1 = 3'd4; raddr2 = 3'd3;
    #1;
    exp = BYP ? 32'h77 : 32'h11;
    checks++;
    if (z_rd1 !== exp) begin errors++; $display("FAIL same_cycle_rd1 got=%h exp=%h", z_rd1, exp); end
    checks++;
    if (z_rd2 !== 32'h23) begin errors++; $display("FAIL same_cycle_other_port got=%h exp=%h", z_rd2, 32'h23); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (z_rd1 !== 32'h77) begin errors++; $display("FAIL same_cycle_after got=%h exp=%h", z_rd1, 32'h77); end
    // Never forward to the zero register or past DEPTH.
    we = 1'b1; waddr = 3'd0; wdata = 32'h99; raddr1 = 3'd0;
    #1;
    checks++;
    if (z_rd1 !== 32'h0) begin errors++; $display("FAIL same_cycle_zero got=%h exp=%h", z_rd1, 32'h0); end
    waddr = 3'd7; raddr1 = 3'd7;
    #1;
    checks++;
    if (s_rd1 !== 32'h0) begin errors++; $display("FAIL same_cycle_oor got=%h exp=%h", s_rd1, 32'h0); end
    we = 1'b0;
    tick();
  endtask

  task automatic test_clrn_mid_write();
    we = 1'b1; waddr = 3'd3; wdata = 32'h99; raddr1 = 3'd4; raddr2 = 3'd3;
    #2 clrn = 1'b0;
    #1;
    checks++;
    if (z_rd1 !== 32'hAA) begin errors++; $display("FAIL clrn_async_w4 got=%h exp=%h", z_rd1, 32'hAA); end
    tick();
    clrn = 1'b1; we = 1'b0;
    #1;
    checks++;
    if (z_rd2 !== 32'hAA) begin errors++; $display("FAIL clrn_write_lost got=%h exp=%h", z_rd2, 32'hAA); end
    checks++;
    if (n_rd2 !== 32'hAA) begin errors++; $display("FAIL clrn_write_lost_n got=%h exp=%h", n_rd2, 32'hAA); end
  endtask

  task automatic test_back_to_back();
    write_word(3'd1, 32'hA1);
    write_word(3'd2, 32'hA2);
    write_word(3'd1, 32'hB1);
    raddr1 = 3'd1; raddr2 = 3'd2;
    #1;
    checks++;
    if (z_rd1 !== 32'hB1) begin errors++; $display("FAIL b2b_w1 got=%h exp=%h", z_rd1, 32'hB1); end
    checks++;
    if (z_rd2 !== 32'hA2) begin errors++; $display("FAIL b2b_w2 got=%h exp=%h", z_rd2, 32'hA2); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero_reg();
    test_sclr();
    test_out_of_range();
    test_same_cycle();
    test_clrn_mid_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
